// File: rtl/ysyx_22050518_mul_seq_pkg.sv
// Shared FSM state codes, operand-signedness encodings and iteration counts for the
// sequential multiplier (optional zero bypass: YSYX_22050518_MUL_ZERO_BYPASS_EN).
package ysyx_22050518_mul_seq_pkg;

  typedef logic [2:0] state_t;

  localparam state_t StIdle  = 3'd0;
  localparam state_t StPrepA = 3'd1;
  localparam state_t StPrepB = 3'd2;
  localparam state_t StCalc  = 3'd3;
  localparam state_t StFixLo = 3'd4;
  localparam state_t StFixHi = 3'd5;
  localparam state_t StDone  = 3'd6;

  typedef logic [1:0] sgn_t;

  localparam sgn_t SgnUu = 2'b00;
  localparam sgn_t SgnSu = 2'b10;
  localparam sgn_t SgnSs = 2'b11;

  localparam int unsigned IterFull = 64;
  localparam int unsigned IterWord = 32;

  // The reserved code 01 behaves as unsigned x unsigned.
  function automatic sgn_t sgn_norm(input sgn_t s);
    return ((s == SgnSs) || (s == SgnSu)) ? s : SgnUu;
  endfunction

endpackage

// File: rtl/ysyx_22050518_add.sv
// Plain XLEN-bit adder with carry-in; the single adder shared by every multiplier state.
module ysyx_22050518_add #(
  parameter int unsigned XLEN = 64
) (
  input  logic [XLEN-1:0] in1,
  input  logic [XLEN-1:0] in2,
  input  logic            c_in,
  output logic [XLEN-1:0] out
);

  assign out = in1 + in2 + {{(XLEN-1){1'b0}}, c_in};

endmodule

// File: rtl/ysyx_22050518_mul_seq.sv
// Radix-2 sequential multiplier: sign-magnitude prep, 64/32 shift-add iterations, 128-bit fixup.
// Define YSYX_22050518_MUL_ZERO_BYPASS_EN to short-circuit zero operands straight to DONE.
module ysyx_22050518_mul_seq
  import ysyx_22050518_mul_seq_pkg::*;
#(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned CNT_W = 7
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            mulw,
  input  logic [1:0]      sgn,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] res_hi,
  output logic [XLEN-1:0] res_lo
);

  localparam int unsigned HalfW = XLEN / 2;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_mulw;
  logic               r_neg_a;
  logic               r_neg_b;
  logic               r_carry;
  logic [XLEN-1:0]    r_mcand;
  logic [XLEN-1:0]    r_hi;
  logic [XLEN-1:0]    r_lo;
  logic [XLEN-1:0]    r_res_hi;
  logic [XLEN-1:0]    r_res_lo;

  sgn_t               w_sgn;
  logic               w_rs1_sgn;
  logic               w_rs2_sgn;
  logic [XLEN-1:0]    w_rs1_ext;
  logic [XLEN-1:0]    w_rs2_ext;
  logic               w_accept;
  logic               w_zero_op;
  logic               w_neg;
  logic               w_last;
  logic [XLEN-1:0]    w_add_a;
  logic [XLEN-1:0]    w_add_b;
  logic               w_add_cin;
  logic [XLEN-1:0]    w_add_sum;
  logic               w_add_cout;
  logic [XLEN-1:0]    w_calc_hi;
  logic [XLEN-1:0]    w_calc_lo;

  assign in_ready  = (r_state == StIdle) && !flush && !rst;
  assign out_valid = (r_state == StDone);
  assign res_hi    = r_res_hi;
  assign res_lo    = r_res_lo;

  assign w_accept  = in_valid && in_ready;
  assign w_sgn     = sgn_norm(sgn);
  assign w_rs1_sgn = (w_sgn != SgnUu);
  assign w_rs2_sgn = (w_sgn == SgnSs);
  assign w_rs1_ext = mulw ? {{HalfW{w_rs1_sgn & rs1[HalfW-1]}}, rs1[HalfW-1:0]} : rs1;
  assign w_rs2_ext = mulw ? {{HalfW{w_rs2_sgn & rs2[HalfW-1]}}, rs2[HalfW-1:0]} : rs2;

`ifdef YSYX_22050518_MUL_ZERO_BYPASS_EN
  assign w_zero_op = mulw ? ((rs1[HalfW-1:0] == '0) || (rs2[HalfW-1:0] == '0))
                          : ((rs1 == '0) || (rs2 == '0));
`else
  assign w_zero_op = 1'b0;
`endif

  assign w_neg  = r_neg_a ^ r_neg_b;
  assign w_last = (r_cnt == (r_mulw ? CNT_W'(IterWord - 1) : CNT_W'(IterFull - 1)));

  always_comb begin
    w_add_a   = '0;
    w_add_b   = '0;
    w_add_cin = 1'b0;
    case (r_state)
      StPrepA: begin
        w_add_a   = r_neg_a ? ~r_mcand : r_mcand;
        w_add_cin = r_neg_a;
      end
      StPrepB: begin
        w_add_a   = r_neg_b ? ~r_lo : r_lo;
        w_add_cin = r_neg_b;
      end
      StCalc: begin
        w_add_a = r_hi;
        w_add_b = r_lo[0] ? r_mcand : '0;
      end
      StFixLo: begin
        w_add_a   = w_neg ? ~r_lo : r_lo;
        w_add_cin = w_neg;
      end
      StFixHi: begin
        w_add_a   = w_neg ? ~r_hi : r_hi;
        w_add_cin = w_neg & r_carry;
      end
      default: ;
    endcase
  end

  ysyx_22050518_add #(
    .XLEN (XLEN)
  ) u_add (
    .in1  (w_add_a),
    .in2  (w_add_b),
    .c_in (w_add_cin),
    .out  (w_add_sum)
  );

  assign w_add_cout = (w_add_a[XLEN-1] & w_add_b[XLEN-1]) |
                      ((w_add_a[XLEN-1] ^ w_add_b[XLEN-1]) & ~w_add_sum[XLEN-1]);

  // {carry, sum, multiplier} shifted right by one: partial product enters lo from the top.
  assign w_calc_hi = {w_add_cout, w_add_sum[XLEN-1:1]};
  assign w_calc_lo = {w_add_sum[0], r_lo[XLEN-1:1]};

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      StIdle:  if (w_accept) w_state_nxt = w_zero_op ? StDone : StPrepA;
      StPrepA: w_state_nxt = StPrepB;
      StPrepB: w_state_nxt = StCalc;
      StCalc:  if (w_last) w_state_nxt = StFixLo;
      StFixLo: w_state_nxt = StFixHi;
      StFixHi: w_state_nxt = StDone;
      StDone:  if (out_ready) w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
    if (flush && (r_state != StIdle)) w_state_nxt = StIdle;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= StIdle;
      r_cnt    <= '0;
      r_mulw   <= 1'b0;
      r_neg_a  <= 1'b0;
      r_neg_b  <= 1'b0;
      r_carry  <= 1'b0;
      r_mcand  <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_res_hi <= '0;
      r_res_lo <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        StIdle: begin
          if (w_accept) begin
            r_cnt   <= '0;
            r_mulw  <= mulw;
            r_neg_a <= w_rs1_sgn & w_rs1_ext[XLEN-1];
            r_neg_b <= w_rs2_sgn & w_rs2_ext[XLEN-1];
            r_mcand <= w_rs1_ext;
            r_hi    <= '0;
            r_lo    <= w_rs2_ext;
            if (w_zero_op) begin
              r_res_hi <= '0;
              r_res_lo <= '0;
            end
          end
        end
        StPrepA: r_mcand <= w_add_sum;
        StPrepB: r_lo <= w_add_sum;
        StCalc: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_last && r_mulw) begin
            // Word product sits in {hi[31:0], lo[63:32]}; realign it to the bottom.
            r_hi <= '0;
            r_lo <= {w_calc_hi[HalfW-1:0], w_calc_lo[XLEN-1:HalfW]};
          end else begin
            r_hi <= w_calc_hi;
            r_lo <= w_calc_lo;
          end
        end
        StFixLo: begin
          r_lo    <= w_add_sum;
          r_carry <= w_add_cout;
        end
        StFixHi: begin
          r_hi <= w_add_sum;
          if (!flush) begin
            r_res_hi <= w_add_sum;
            r_res_lo <= r_mulw ? {{HalfW{r_lo[HalfW-1]}}, r_lo[HalfW-1:0]} : r_lo;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/ysyx_22050518_mul_seq.md
YSYX_22050518_MUL_SEQ -- requirements
Module: ysyx_22050518_mul_seq

Interface
REQ-001 SHALL have parameter XLEN, default 64, datapath width; only 64 is supported.
REQ-002 SHALL have parameter CNT_W, default 7, iteration counter width.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port flush  input  1  abort any operation in flight.
REQ-006 SHALL have port in_valid  input  1  operands valid.
REQ-007 SHALL have port in_ready  output  1  high only in IDLE with flush low.
REQ-008 SHALL have port mulw  input  1  32-bit word multiply.
REQ-009 SHALL have port sgn  input  2  operand signedness: 00 uu, 11 ss, 10 rs1-signed/rs2-unsigned; 01 is treated as 00.
REQ-010 SHALL have port rs1  input  64  multiplicand.
REQ-011 SHALL have port rs2  input  64  multiplier.
REQ-012 SHALL have port out_valid  output  1  result valid.
REQ-013 SHALL have port out_ready  input  1  consumer accepts result.
REQ-014 SHALL have port res_hi  output  64  product[127:64].
REQ-015 SHALL have port res_lo  output  64  product[63:0], or the mulw result.

Function
REQ-016 SHALL accept an operation on the edge where in_valid & in_ready; operands, mulw and sgn are latched there (T0).
REQ-017 SHALL implement FSM IDLE->PREP_A->PREP_B->CALC->FIX_LO->FIX_HI->DONE->IDLE; every add uses one shared 64-bit adder instance.
REQ-018 PREP_A SHALL replace the latched multiplicand with its two's-complement magnitude (~x + 1 via the adder) when it is signed-negative; otherwise it passes through. PREP_B SHALL do the same for the multiplier.
REQ-019 Under mulw, operands SHALL first be sign- or zero-extended from bit 31 according to sgn.
REQ-020 CALC SHALL do one radix-2 shift-add per cycle: 64 iterations, or 32 under mulw, counted by the CNT_W counter.
REQ-021 The adder carry-out SHALL be derived as (a63&b63)|((a63^b63)&~s63).
REQ-022 FIX_LO and FIX_HI SHALL negate the 128-bit product when the operand signs differ; FIX_HI SHALL consume the carry-out from FIX_LO. When no negation is needed, both states pass the product through. Both states are always taken.
REQ-023 Fixed latency: out_valid SHALL first be high at T0+69 for 64-bit and T0+37 for mulw.
REQ-024 Under mulw, res_lo SHALL be sign-extended product[31:0].
REQ-025 DONE SHALL hold out_valid, res_hi and res_lo stable until out_ready; on the out_ready edge the FSM returns to IDLE.
REQ-026 in_ready SHALL be low in every state other than IDLE, including the DONE->IDLE edge cycle.
REQ-027 flush in any non-IDLE state SHALL return the FSM to IDLE next cycle with out_valid low and no result delivered.
REQ-028 flush takes priority over out_ready and over in_valid.
REQ-029 When out_valid is low, res_hi and res_lo SHALL hold their last value.

Reset
REQ-030 While rst is high: state = IDLE, counter = 0, out_valid = 0, res_hi = res_lo = 0, in_ready = 0.
REQ-031 in_ready SHALL be 1 in the first cycle after rst deasserts.
REQ-032 rst mid-operation SHALL discard the operation; rst has priority over flush.

Configuration
REQ-033 Macro YSYX_22050518_MUL_ZERO_BYPASS_EN defined: if either width-selected operand is zero at acceptance, the FSM SHALL go directly to DONE, with out_valid at T0+1 and result 0.
REQ-034 Macro undefined: zero operands SHALL take the full fixed latency; the results are identical either way.

Structure
REQ-035 A shared package SHALL hold the FSM state enum, the sgn encodings, and the iteration-count constants (64, 32).
REQ-036 The single sub-module SHALL be ysyx_22050518_add (in1, in2, c_in, out), instantiated exactly once; its inputs are muxed by state.

Verification
REQ-037 Unsigned: rs1=3, rs2=5, sgn=00 -> at T0+69, res_lo=15 and res_hi=0.
REQ-038 Signed: rs1=-1, rs2=-1, sgn=11 -> res_hi=0 and res_lo=1. Separately, rs1=-2, rs2=3 -> res_hi=all ones and res_lo=-6.
REQ-039 Mixed, full width: rs1=-1, rs2=0xFFFF_FFFF_FFFF_FFFF, sgn=10 -> res_hi=all ones and res_lo=1.
REQ-040 mulw: rs1=0x7FFF_FFFF, rs2=2, sgn=11 -> at T0+37, res_lo=0xFFFF_FFFF_FFFF_FFFE.
REQ-041 Backpressure and flush:
- Hold out_ready low for 10 cycles in DONE -> outputs stable and in_ready=0 throughout.
- Assert flush in CALC cycle 20 -> IDLE next cycle, out_valid never asserted.
REQ-042 With the macro defined: rs2=0 -> out_valid at T0+1 with result 0. Without the macro: the same stimulus gives out_valid at T0+69.
